// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one 8N1 UART transmitter between two byte requesters
module uart_tx_arbiter #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   output logic       tx,
   output logic       busy,
   output logic       grant_id
);
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_d;
   logic [TW-1:0] timer, timer_d;
   logic [2:0]    idx, idx_d;
   logic [7:0]    shreg, shreg_d;
   logic          tx_d, grant_d, last_grant, last_d;
   logic          g0, g1, hs0, hs1, bit_end;

   // with both valid, the requester that did not win last time is granted
   assign g0 = req0_valid && (!req1_valid || last_grant);
   assign g1 = req1_valid && (!req0_valid || !last_grant);
   assign req0_ready = (state == IDLE) && g0 && resetn;
   assign req1_ready = (state == IDLE) && g1 && resetn;
   assign hs0 = req0_valid && req0_ready;
   assign hs1 = req1_valid && req1_ready;
   assign busy = state != IDLE;
   assign bit_end = timer == LAST;

   always_comb begin
      state_d = state;
      timer_d = bit_end ? '0 : timer + 1'b1;
      idx_d   = idx;
      shreg_d = shreg;
      grant_d = grant_id;
      last_d  = last_grant;
      case (state)
         IDLE: begin
            timer_d = '0;
            if (hs0 || hs1) begin
               state_d = START;
               shreg_d = hs1 ? req1_data : req0_data;
               grant_d = hs1;
               last_d  = hs1;
            end
         end
         START: if (bit_end) begin
            state_d = DATA;
            idx_d   = '0;
         end
         DATA: if (bit_end) begin
            shreg_d = shreg >> 1;
            idx_d   = idx + 1'b1;
            if (idx == 3'd7) state_d = STOP;
         end
         STOP: if (bit_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // tx is registered, so it is derived from the upcoming state
      tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shreg_d[0] : 1'b1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         timer      <= '0;
         idx        <= '0;
         shreg      <= '0;
         tx         <= 1'b1;
         grant_id   <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         state      <= state_d;
         timer      <= timer_d;
         idx        <= idx_d;
         shreg      <= shreg_d;
         tx         <= tx_d;
         grant_id   <= grant_d;
         last_grant <= last_d;
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenario bench for the two-requester UART transmitter
module tb_uart_tx_arbiter;
   localparam int C = 4;

   logic       clk, resetn;
   logic       req0_valid, req1_valid, req0_ready, req1_ready;
   logic [7:0] req0_data, req1_data;
   logic       tx, busy, grant_id;
   int         cmp, err;

   uart_tx_arbiter #(.CLKS_PER_BIT(C)) dut (
      .clk(clk), .resetn(resetn),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .tx(tx), .busy(busy), .grant_id(grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick;
      @(negedge clk);
   endtask

   // called in the handshake cycle; samples the 10*C cycles of the frame that follows
   task automatic frame(input int chg_at, output logic [7:0] d, output int busy_n,
                        output logic ok, output logic r0);
      logic v;
      int   j, p;
      d = 8'h00; busy_n = 0; ok = 1'b1; r0 = 1'b0; v = 1'b0;
      for (int k = 1; k <= 10 * C; k++) begin
         tick();
         busy_n += busy ? 1 : 0;
         r0 |= req0_ready;
         p = (k - 1) % C;
         j = (k - 1) / C;
         if (p == 0) v = tx;
         else if (tx !== v) ok = 1'b0;
         if (p == C - 1) begin
            if (j == 0 && v !== 1'b0) ok = 1'b0;
            else if (j == 9 && v !== 1'b1) ok = 1'b0;
            else if (j > 0 && j < 9) d[j-1] = v;
         end
         if (k == chg_at) req0_data = 8'hF0;
      end
   endtask

   task automatic test_reset;
      resetn = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
      req0_data = 8'h11; req1_data = 8'h22;
      repeat (3) tick();
      cmp++; if (tx !== 1'b1) begin err++; $display("FAIL reset_tx: got %b want 1", tx); end
      cmp++; if (busy !== 1'b0) begin err++; $display("FAIL reset_busy: got %b want 0", busy); end
      cmp++; if (req0_ready !== 1'b0) begin err++; $display("FAIL reset_ready0: got %b want 0", req0_ready); end
      cmp++; if (req1_ready !== 1'b0) begin err++; $display("FAIL reset_ready1: got %b want 0", req1_ready); end
      cmp++; if (grant_id !== 1'b0) begin err++; $display("FAIL reset_grant: got %b want 0", grant_id); end
   endtask

   task automatic test_single;
      logic [7:0] d;
      int         bn;
      logic       ok, r0;
      resetn = 1'b1; req1_valid = 1'b0; req0_data = 8'h55;
      #1;
      cmp++; if (req0_ready !== 1'b1) begin err++; $display("FAIL single_ready0: got %b want 1", req0_ready); end
      cmp++; if (req1_ready !== 1'b0) begin err++; $display("FAIL single_ready1: got %b want 0", req1_ready); end
      frame(0, d, bn, ok, r0);
      req0_valid = 1'b0;
      cmp++; if (d !== 8'h55) begin err++; $display("FAIL single_data: got %h want 55", d); end
      cmp++; if (ok !== 1'b1) begin err++; $display("FAIL single_shape: got %b want 1", ok); end
      cmp++; if (bn !== 40) begin err++; $display("FAIL single_busy_cycles: got %0d want 40", bn); end
      cmp++; if (grant_id !== 1'b0) begin err++; $display("FAIL single_grant: got %b want 0", grant_id); end
      tick();
      cmp++; if (busy !== 1'b0 || tx !== 1'b1) begin err++; $display("FAIL single_idle: got busy=%b tx=%b want busy=0 tx=1", busy, tx); end
   endtask

   task automatic test_repeat;
      logic [7:0] d;
      int         bn;
      logic       ok, r0, any_r0;
      any_r0 = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b1; req1_data = 8'h81;
      for (int i = 0; i < 3; i++) begin
         #1;
         any_r0 |= req0_ready;
         cmp++; if (req1_ready !== 1'b1) begin err++; $display("FAIL repeat_ready1[%0d]: got %b want 1", i, req1_ready); end
         frame(0, d, bn, ok, r0);
         any_r0 |= r0;
         cmp++; if (d !== 8'h81 || ok !== 1'b1) begin err++; $display("FAIL repeat_frame[%0d]: got data=%h shape=%b want 81 1", i, d, ok); end
         cmp++; if (grant_id !== 1'b1) begin err++; $display("FAIL repeat_grant[%0d]: got %b want 1", i, grant_id); end
         if (i == 2) req1_valid = 1'b0;
         tick();
      end
      cmp++; if (any_r0 !== 1'b0) begin err++; $display("FAIL repeat_ready0_seen: got %b want 0", any_r0); end
   endtask

   task automatic test_round_robin;
      logic [7:0] d;
      int         bn;
      logic       ok, r0, id;
      req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 8'hA5; req1_data = 8'h3C;
      for (int i = 0; i < 4; i++) begin
         id = i[0];
         #1;
         cmp++; if (req0_ready !== !id || req1_ready !== id) begin
            err++; $display("FAIL rr_ready[%0d]: got r0=%b r1=%b want r0=%b r1=%b", i, req0_ready, req1_ready, !id, id);
         end
         frame(0, d, bn, ok, r0);
         cmp++; if (d !== (id ? 8'h3C : 8'hA5) || ok !== 1'b1) begin
            err++; $display("FAIL rr_frame[%0d]: got data=%h shape=%b want %h 1", i, d, ok, id ? 8'h3C : 8'hA5);
         end
         cmp++; if (grant_id !== id) begin err++; $display("FAIL rr_grant[%0d]: got %b want %b", i, grant_id, id); end
         if (i == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
         tick();
         cmp++; if (tx !== 1'b1 || busy !== 1'b0) begin err++; $display("FAIL rr_gap[%0d]: got tx=%b busy=%b want 1 0", i, tx, busy); end
      end
   endtask

   task automatic test_stability;
      logic [7:0] d;
      int         bn;
      logic       ok, r0;
      req0_valid = 1'b1; req0_data = 8'h0F;
      #1;
      cmp++; if (req0_ready !== 1'b1) begin err++; $display("FAIL stab_ready0: got %b want 1", req0_ready); end
      frame(2, d, bn, ok, r0);
      req0_valid = 1'b0;
      cmp++; if (d !== 8'h0F || ok !== 1'b1) begin err++; $display("FAIL stab_data: got data=%h shape=%b want 0f 1", d, ok); end
      tick();
   endtask

   task automatic test_reset_mid;
      req0_valid = 1'b1; req1_valid = 1'b0; req0_data = 8'h00;
      #1;
      cmp++; if (req0_ready !== 1'b1) begin err++; $display("FAIL mid_ready0: got %b want 1", req0_ready); end
      repeat (18) tick();
      cmp++; if (tx !== 1'b0 || busy !== 1'b1) begin err++; $display("FAIL mid_bit3: got tx=%b busy=%b want 0 1", tx, busy); end
      resetn = 1'b0; req1_valid = 1'b1;
      #1;
      cmp++; if (tx !== 1'b1 || busy !== 1'b0) begin err++; $display("FAIL mid_abort: got tx=%b busy=%b want 1 0", tx, busy); end
      cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
         err++; $display("FAIL mid_ready_in_reset: got r0=%b r1=%b want 0 0", req0_ready, req1_ready);
      end
      repeat (2) tick();
      resetn = 1'b1;
      #1;
      cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         err++; $display("FAIL mid_first_grant: got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
      end
      tick();
      cmp++; if (grant_id !== 1'b0 || busy !== 1'b1 || tx !== 1'b0) begin
         err++; $display("FAIL mid_restart: got grant=%b busy=%b tx=%b want 0 1 0", grant_id, busy, tx);
      end
   endtask

   initial begin
      cmp = 0; err = 0;
      test_reset();
      test_single();
      test_repeat();
      test_round_robin();
      test_stability();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
      $finish;
   end
endmodule
